// File: rtl/cia_access_ctrl_if.sv
// cia_access_ctrl_if: synchronized CIA bus side and register-file side of cia_access_ctrl
// slave = the access controller, master = bus/register-file environment.
interface cia_access_ctrl_if #(parameter int ADDR_W = 4);
    logic              cs_n;
    logic              reg_decode;
    logic              e;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic [7:0]        reg_rdata;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        data_out;
    logic              data_oe;
    logic              timeout;
    modport slave (
        input  cs_n, reg_decode, e, rw, addr, data_in, reg_rdata,
        output reg_addr, reg_wdata, reg_wr, reg_rd, data_out, data_oe, timeout
    );
    modport master (
        output cs_n, reg_decode, e, rw, addr, data_in, reg_rdata,
        input  reg_addr, reg_wdata, reg_wr, reg_rd, data_out, data_oe, timeout
    );
endinterface

// File: rtl/cia_access_ctrl.sv
// cia_access_ctrl: turns E-clock-synchronous CIA accesses into single-cycle reg_rd/reg_wr strobes
// Define CIA_TIMEOUT_EN to build the WAIT_E/ACCESS watchdog (TIMEOUT, CNT_W parameters).
module cia_access_ctrl #(
    parameter int ADDR_W = 4
`ifdef CIA_TIMEOUT_EN
    ,parameter int TIMEOUT = 96
    ,parameter int CNT_W   = 7
`endif
) (
    input logic clk,
    input logic rst,
    cia_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_E, ACCESS, HOLD} state_t;
    state_t            r_state;
    logic              r_e_d;
    logic              r_rw;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_wr;
    logic              r_reg_rd;
    logic [7:0]        r_data_out;
    logic              r_data_oe;
    logic              w_e_rise;
    logic              w_e_fall;
    logic              w_to;
    assign w_e_rise = bus.e & ~r_e_d;
    assign w_e_fall = ~bus.e & r_e_d;
`ifdef CIA_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_cnt_en;
    assign w_cnt_en = (r_state == WAIT_E) || (r_state == ACCESS);
    // chip-select release outranks the watchdog, so no pulse on a normal deselect
    assign w_to = w_cnt_en && !bus.cs_n && (r_cnt == CNT_W'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        r_cnt     <= (rst || r_state == IDLE) ? '0 : (w_cnt_en && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        r_timeout <= rst ? 1'b0 : w_to;
    end
    assign bus.timeout = r_timeout;
`else
    assign w_to        = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_e_d       <= 1'b0;
            r_rw        <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
        end else begin
            r_e_d    <= bus.e;
            r_reg_wr <= 1'b0;
            r_reg_rd <= 1'b0;
            case (r_state)
                IDLE: if (!bus.cs_n && bus.reg_decode) r_state <= WAIT_E;
                WAIT_E: begin
                    if (bus.cs_n) r_state <= IDLE;
                    else if (w_to) r_state <= HOLD;
                    else if (w_e_rise && bus.reg_decode) begin
                        r_state    <= ACCESS;
                        r_reg_addr <= bus.addr;
                        r_rw       <= bus.rw;
                        r_reg_rd   <= bus.rw;
                    end
                end
                ACCESS: begin
                    if (bus.cs_n || w_to) begin
                        r_state   <= bus.cs_n ? IDLE : HOLD;
                        r_data_oe <= 1'b0;
                    end else begin
                        if (r_reg_rd) begin
                            r_data_out <= bus.reg_rdata;
                            r_data_oe  <= 1'b1;
                        end
                        if (w_e_fall) begin
                            r_state <= HOLD;
                            if (!r_rw) begin
                                r_reg_wdata <= bus.data_in;
                                r_reg_wr    <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: if (bus.cs_n) begin
                    r_state   <= IDLE;
                    r_data_oe <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.reg_addr  = r_reg_addr;
    assign bus.reg_wdata = r_reg_wdata;
    assign bus.reg_wr    = r_reg_wr;
    assign bus.reg_rd    = r_reg_rd;
    assign bus.data_out  = r_data_out;
    assign bus.data_oe   = r_data_oe;
endmodule

// File: tb/tb_cia_access_ctrl.sv
// tb_cia_access_ctrl: directed CIA accesses; stimulus queues expected strobes, a negedge monitor checks them
module tb_cia_access_ctrl;
    localparam int ADDR_W = 4;
    localparam int K_RD = 0, K_WR = 1, K_OER = 2, K_OEF = 3, K_TO = 4;
    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_oe = 1'b0;
    exp_t q[$];
    cia_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();
    cia_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic push(int kind, logic [3:0] a, logic [7:0] d, int at);
        exp_t x;
        x.kind = kind; x.addr = a; x.data = d; x.cyc = at;
        q.push_back(x);
    endtask
    task automatic pop_chk(int kind, string name);
        exp_t x;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
            return;
        end
        x = q.pop_front();
        chk({name, " kind"}, kind, x.kind);
        chk({name, " cycle"}, cyc, x.cyc);
        if (kind == K_RD || kind == K_WR) chk({name, " reg_addr"}, bus.reg_addr, x.addr);
        if (kind == K_WR) chk({name, " reg_wdata"}, bus.reg_wdata, x.data);
        if (kind == K_OER) chk({name, " data_out"}, bus.data_out, x.data);
    endtask
    always @(negedge clk) begin
        if (bus.reg_rd) pop_chk(K_RD, "reg_rd");
        if (bus.reg_wr) pop_chk(K_WR, "reg_wr");
        if (bus.data_oe && !prev_oe) pop_chk(K_OER, "data_oe rise");
        if (!bus.data_oe && prev_oe) pop_chk(K_OEF, "data_oe fall");
        if (bus.timeout) pop_chk(K_TO, "timeout");
        prev_oe = bus.data_oe;
    end
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic start(logic r, logic [3:0] a, logic [7:0] d);
        bus.cs_n = 1'b0; bus.reg_decode = 1'b1; bus.rw = r; bus.addr = a; bus.data_in = d;
        tick(2);
    endtask
    task automatic e_cycle(bit strobe, bit is_rd, logic [3:0] ea, logic [7:0] ed);
        if (strobe && is_rd) begin
            push(K_RD, ea, 8'h00, cyc + 1);
            push(K_OER, 4'h0, ed, cyc + 2);
        end
        bus.e = 1'b1;
        tick(20);
        if (strobe && !is_rd) push(K_WR, ea, ed, cyc + 1);
        bus.e = 1'b0;
        tick(20);
    endtask
    task automatic release_cs(bit oe);
        if (oe) push(K_OEF, 4'h0, 8'h00, cyc + 1);
        bus.cs_n = 1'b1; bus.reg_decode = 1'b0;
        tick(3);
    endtask
    initial begin
        bus.cs_n = 1'b1; bus.reg_decode = 1'b0; bus.e = 1'b0; bus.rw = 1'b0;
        bus.addr = '0; bus.data_in = '0; bus.reg_rdata = '0;
        tick(3);
        rst = 1'b0;
        chk("reset reg_rd", bus.reg_rd, 0);
        chk("reset reg_wr", bus.reg_wr, 0);
        chk("reset data_oe", bus.data_oe, 0);
        chk("reset data_out", bus.data_out, 0);
        chk("reset reg_addr", bus.reg_addr, 0);
        chk("reset reg_wdata", bus.reg_wdata, 0);
        chk("reset timeout", bus.timeout, 0);
        // write A <- 5C
        start(1'b0, 4'hA, 8'h5C);
        e_cycle(1'b1, 1'b0, 4'hA, 8'h5C);
        release_cs(1'b0);
        chk("write reg_addr held", bus.reg_addr, 4'hA);
        chk("write reg_wdata held", bus.reg_wdata, 8'h5C);
        // read 3 -> C7, rw/addr/data change after e_rise must be ignored
        start(1'b1, 4'h3, 8'h00);
        bus.reg_rdata = 8'hC7;
        push(K_RD, 4'h3, 8'h00, cyc + 1);
        push(K_OER, 4'h0, 8'hC7, cyc + 2);
        bus.e = 1'b1;
        tick(3);
        bus.rw = 1'b0; bus.addr = 4'hF; bus.data_in = 8'hEE;
        tick(17);
        bus.e = 1'b0;
        tick(20);
        chk("read oe through hold", bus.data_oe, 1);
        chk("read reg_addr latched", bus.reg_addr, 4'h3);
        release_cs(1'b1);
        chk("read oe after release", bus.data_oe, 0);
        chk("read no write", bus.reg_wdata, 8'h5C);
        // write aborted five clocks after e_rise
        start(1'b0, 4'h6, 8'h11);
        bus.e = 1'b1;
        tick(5);
        bus.cs_n = 1'b1; bus.reg_decode = 1'b0;
        tick(15);
        bus.e = 1'b0;
        tick(20);
        chk("abort data_oe", bus.data_oe, 0);
        chk("abort reg_wdata kept", bus.reg_wdata, 8'h5C);
        // e_rise without reg_decode is ignored, next one accesses
        start(1'b0, 4'h2, 8'h22);
        bus.reg_decode = 1'b0;
        e_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        bus.reg_decode = 1'b1;
        e_cycle(1'b1, 1'b0, 4'h2, 8'h22);
        release_cs(1'b0);
        // cs held over three E periods -> single strobe, then one more after re-select
        start(1'b0, 4'h7, 8'h33);
        e_cycle(1'b1, 1'b0, 4'h7, 8'h33);
        bus.data_in = 8'h99;
        e_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        e_cycle(1'b0, 1'b0, 4'h0, 8'h00);
        release_cs(1'b0);
        chk("hold reg_wdata", bus.reg_wdata, 8'h33);
        start(1'b0, 4'h8, 8'h44);
        e_cycle(1'b1, 1'b0, 4'h8, 8'h44);
        release_cs(1'b0);
        // reset one clock after reg_rd
        start(1'b1, 4'h9, 8'h00);
        bus.reg_rdata = 8'h5A;
        push(K_RD, 4'h9, 8'h00, cyc + 1);
        bus.e = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst reg_rd", bus.reg_rd, 0);
        chk("rst reg_wr", bus.reg_wr, 0);
        chk("rst data_oe", bus.data_oe, 0);
        chk("rst data_out", bus.data_out, 0);
        chk("rst reg_addr", bus.reg_addr, 0);
        chk("rst reg_wdata", bus.reg_wdata, 0);
        tick(18);
        bus.e = 1'b0;
        tick(20);
        e_cycle(1'b1, 1'b1, 4'h9, 8'h5A);
        release_cs(1'b1);
        // selected with E stuck low
        bus.cs_n = 1'b0; bus.reg_decode = 1'b1; bus.rw = 1'b0;
`ifdef CIA_TIMEOUT_EN
        push(K_TO, 4'h0, 8'h00, cyc + 97);
`endif
        tick(120);
        chk("stuck timeout level", bus.timeout, 0);
        release_cs(1'b0);
        tick(5);
        chk("scoreboard drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
